// File: rtl/op_dispatcher_pkg.sv
// op_dispatcher_pkg: opcode constants, route encodings, FSM state type and the
// route-decode helper shared by the dispatcher and the ALU router.
//
// The opcode values and route encodings must stay identical to the router's own
// copy; route_decode() is the single definition of how cond_sel=3 picks a base.
package op_dispatcher_pkg;

    localparam int unsigned SelW  = 2;
    localparam int unsigned OpW   = 4;
    localparam int unsigned DataW = 16;
    localparam int unsigned ResW  = 32;

    // Opcodes are grouped by base: binary, then decimal, then duodecimal.
    localparam logic [OpW-1:0] OP_BIN_ADD   = 4'h0;
    localparam logic [OpW-1:0] OP_BIN_SUB   = 4'h1;
    localparam logic [OpW-1:0] OP_BIN_MUL   = 4'h2;
    localparam logic [OpW-1:0] OP_DEC_ADD   = 4'h3;
    localparam logic [OpW-1:0] OP_DEC_SUB   = 4'h4;
    localparam logic [OpW-1:0] OP_DEC_MUL10 = 4'h5;
    localparam logic [OpW-1:0] OP_DUO_ADD   = 4'h6;
    localparam logic [OpW-1:0] OP_DUO_SUB   = 4'h7;
    localparam logic [OpW-1:0] OP_DUO_MUL   = 4'h8;

    localparam logic [SelW-1:0] ROUTE_B2    = 2'd0;
    localparam logic [SelW-1:0] ROUTE_B10   = 2'd1;
    localparam logic [SelW-1:0] ROUTE_B12   = 2'd2;
    localparam logic [SelW-1:0] ROUTE_BY_OP = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StHold
    } disp_state_e;

    // Effective route: explicit selects pass through, ROUTE_BY_OP decodes the
    // opcode range. Never returns ROUTE_BY_OP.
    function automatic logic [SelW-1:0] route_decode(input logic [SelW-1:0] cond_sel,
                                                     input logic [OpW-1:0]  opcode);
        if (cond_sel != ROUTE_BY_OP) begin
            return cond_sel;
        end
        if (opcode <= OP_BIN_MUL) begin
            return ROUTE_B2;
        end
        if (opcode <= OP_DEC_MUL10) begin
            return ROUTE_B10;
        end
        return ROUTE_B12;
    endfunction

endpackage

// File: rtl/op_dispatcher_fifo.sv
// cmd_fifo: synchronous FIFO with registered count, full and empty flags.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_push, i_wdata   write request and data (ignored when full)
//   i_pop             read request (ignored when empty)
//   o_rdata           head entry, valid while !o_empty
//   o_full, o_empty   status, decoded from the registered count
//   o_count           number of stored entries
//
// No pass-through: a push into an empty FIFO is visible at o_rdata one cycle later.
module cmd_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [CntW-1:0]  r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // Storage carries no reset; the pointers and count define what is valid.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CntW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/op_dispatcher.sv
// op_dispatcher: command front-end for the multi-base ALU router.
//
// Queues commands in cmd_fifo and issues them one at a time to the router,
// holding rt_* stable until rt_done, then returns result and tag over rsp_*.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   cmd_valid/cmd_ready, cmd_*       command input (cmd_ready = FIFO not full)
//   rt_start, rt_cond_sel/opcode/a/b start pulse and held operands to router
//   rt_busy, rt_done, rt_result      router status, done pulse and result
//   rsp_valid/rsp_ready, rsp_*       response output (result + originating tag)
//   disp_busy                        FSM not idle or FIFO not empty
//   cnt_b2, cnt_b10, cnt_b12         issued-command counters per base
//
// Build option: define DISPATCH_STATS_EN to enable the per-base counters;
// otherwise the counter ports are tied to zero.
module op_dispatcher
    import op_dispatcher_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [SelW-1:0]   cmd_cond_sel,
    input  logic [OpW-1:0]    cmd_opcode,
    input  logic [DataW-1:0]  cmd_a,
    input  logic [DataW-1:0]  cmd_b,
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic              rt_start,
    output logic [SelW-1:0]   rt_cond_sel,
    output logic [OpW-1:0]    rt_opcode,
    output logic [DataW-1:0]  rt_a,
    output logic [DataW-1:0]  rt_b,
    input  logic              rt_busy,
    input  logic              rt_done,
    input  logic [ResW-1:0]   rt_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ResW-1:0]   rsp_result,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              disp_busy,
    output logic [CNT_W-1:0]  cnt_b2,
    output logic [CNT_W-1:0]  cnt_b10,
    output logic [CNT_W-1:0]  cnt_b12
);

    localparam int unsigned CmdW = SelW + OpW + 2 * DataW + TAG_W;

    disp_state_e               r_state;
    disp_state_e               w_state_d;
    logic                      w_issue;
    logic                      w_capture;
    logic                      w_rsp_fire;

    logic                      r_rt_start;
    logic [SelW-1:0]           r_rt_cond_sel;
    logic [OpW-1:0]            r_rt_opcode;
    logic [DataW-1:0]          r_rt_a;
    logic [DataW-1:0]          r_rt_b;
    logic [TAG_W-1:0]          r_tag;
    logic                      r_rsp_valid;
    logic [ResW-1:0]           r_rsp_result;
    logic [TAG_W-1:0]          r_rsp_tag;

    logic [CmdW-1:0]           w_fifo_wdata;
    logic [CmdW-1:0]           w_fifo_rdata;
    logic                      w_fifo_full;
    logic                      w_fifo_empty;
    logic [$clog2(DEPTH):0]    w_fifo_count;
    logic [SelW-1:0]           w_head_cond_sel;
    logic [OpW-1:0]            w_head_opcode;
    logic [DataW-1:0]          w_head_a;
    logic [DataW-1:0]          w_head_b;
    logic [TAG_W-1:0]          w_head_tag;
    logic                      w_unused;

    assign w_fifo_wdata = {cmd_cond_sel, cmd_opcode, cmd_a, cmd_b, cmd_tag};
    assign {w_head_cond_sel, w_head_opcode, w_head_a, w_head_b, w_head_tag} = w_fifo_rdata;

    cmd_fifo #(
        .WIDTH (CmdW),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (cmd_valid),
        .i_wdata (w_fifo_wdata),
        .i_pop   (w_issue),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // rt_busy is informational; the FSM tracks the outstanding op itself.
    assign w_unused = ^{rt_busy, w_fifo_count};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_issue    = 1'b0;
        w_capture  = 1'b0;
        w_rsp_fire = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!w_fifo_empty) begin
                    w_issue   = 1'b1;
                    w_state_d = StWait;
                end
            end
            StWait: begin
                if (rt_done) begin
                    w_capture = 1'b1;
                    w_state_d = StHold;
                end
            end
            StHold: begin
                if (r_rsp_valid && rsp_ready) begin
                    w_rsp_fire = 1'b1;
                    w_state_d  = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Router operands change only on issue: the router re-derives its route
    // from them every cycle, so they must not follow the FIFO head.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rt_start    <= 1'b0;
            r_rt_cond_sel <= '0;
            r_rt_opcode   <= '0;
            r_rt_a        <= '0;
            r_rt_b        <= '0;
            r_tag         <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_result  <= '0;
            r_rsp_tag     <= '0;
        end else begin
            r_rt_start <= w_issue;
            if (w_issue) begin
                r_rt_cond_sel <= w_head_cond_sel;
                r_rt_opcode   <= w_head_opcode;
                r_rt_a        <= w_head_a;
                r_rt_b        <= w_head_b;
                r_tag         <= w_head_tag;
            end
            if (w_capture) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_result <= rt_result;
                r_rsp_tag    <= r_tag;
            end else if (w_rsp_fire) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

`ifdef DISPATCH_STATS_EN
    logic [CNT_W-1:0] r_cnt_b2;
    logic [CNT_W-1:0] r_cnt_b10;
    logic [CNT_W-1:0] r_cnt_b12;
    logic [SelW-1:0]  w_route;

    assign w_route = route_decode(w_head_cond_sel, w_head_opcode);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_b2  <= '0;
            r_cnt_b10 <= '0;
            r_cnt_b12 <= '0;
        end else if (w_issue) begin
            case (w_route)
                ROUTE_B2:  r_cnt_b2  <= r_cnt_b2 + CNT_W'(1);
                ROUTE_B10: r_cnt_b10 <= r_cnt_b10 + CNT_W'(1);
                default:   r_cnt_b12 <= r_cnt_b12 + CNT_W'(1);
            endcase
        end
    end

    assign cnt_b2  = r_cnt_b2;
    assign cnt_b10 = r_cnt_b10;
    assign cnt_b12 = r_cnt_b12;
`else
    assign cnt_b2  = '0;
    assign cnt_b10 = '0;
    assign cnt_b12 = '0;
`endif

    assign cmd_ready   = !w_fifo_full;
    assign rt_start    = r_rt_start;
    assign rt_cond_sel = r_rt_cond_sel;
    assign rt_opcode   = r_rt_opcode;
    assign rt_a        = r_rt_a;
    assign rt_b        = r_rt_b;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_result  = r_rsp_result;
    assign rsp_tag     = r_rsp_tag;
    assign disp_busy   = (r_state != StIdle) || !w_fifo_empty;

endmodule

// File: tb/tb_op_dispatcher.sv
// tb_op_dispatcher: directed self-checking bench for op_dispatcher.
// The bench plays the router (drives rt_done/rt_result by hand) and the
// response consumer. Inputs change and outputs are sampled on the falling edge.
module tb_op_dispatcher;
    import op_dispatcher_pkg::*;

`ifdef DISPATCH_STATS_EN
    localparam bit StatsEn = 1'b1;
`else
    localparam bit StatsEn = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_cond_sel;
    logic [3:0]  cmd_opcode;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic [3:0]  cmd_tag;
    logic        rt_start;
    logic [1:0]  rt_cond_sel;
    logic [3:0]  rt_opcode;
    logic [15:0] rt_a;
    logic [15:0] rt_b;
    logic        rt_busy;
    logic        rt_done;
    logic [31:0] rt_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_tag;
    logic        disp_busy;
    logic [15:0] cnt_b2;
    logic [15:0] cnt_b10;
    logic [15:0] cnt_b12;

    int checks = 0;
    int errors = 0;
    int overlaps = 0;
    bit outstanding = 1'b0;

    op_dispatcher #(
        .DEPTH (4),
        .TAG_W (4),
        .CNT_W (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_cond_sel (cmd_cond_sel),
        .cmd_opcode   (cmd_opcode),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_tag      (cmd_tag),
        .rt_start     (rt_start),
        .rt_cond_sel  (rt_cond_sel),
        .rt_opcode    (rt_opcode),
        .rt_a         (rt_a),
        .rt_b         (rt_b),
        .rt_busy      (rt_busy),
        .rt_done      (rt_done),
        .rt_result    (rt_result),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_tag      (rsp_tag),
        .disp_busy    (disp_busy),
        .cnt_b2       (cnt_b2),
        .cnt_b10      (cnt_b10),
        .cnt_b12      (cnt_b12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A start while a previous op has not yet been handed back is an overlap.
    always @(posedge clk) begin
        if (rst) begin
            outstanding <= 1'b0;
        end else if (rt_start) begin
            if (outstanding) overlaps <= overlaps + 1;
            outstanding <= 1'b1;
        end else if (rsp_valid && rsp_ready) begin
            outstanding <= 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] cs, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] tag);
        chk("push_ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_cond_sel = cs; cmd_opcode = op;
        cmd_a = a; cmd_b = b; cmd_tag = tag;
        cyc();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        while (rt_start !== 1'b1 && n < 10) begin
            cyc();
            n++;
        end
        chk(name, rt_start, 1'b1);
    endtask

    // Entered in WAIT with rt_start already low; returns after the handshake.
    task automatic serve(input logic [3:0] tag, input logic [15:0] a, input logic [31:0] res);
        chk("srv_start_low", rt_start, 1'b0);
        chk("srv_a_held", rt_a, a);
        chk("srv_no_rsp_yet", rsp_valid, 1'b0);
        rt_done = 1'b1; rt_result = res;
        cyc();
        rt_done = 1'b0; rt_result = 32'hDEAD_BEEF;
        chk("srv_rsp_valid", rsp_valid, 1'b1);
        chk("srv_rsp_result", rsp_result, res);
        chk("srv_rsp_tag", rsp_tag, tag);
        cyc();
        chk("srv_hold_valid", rsp_valid, 1'b1);
        chk("srv_hold_result", rsp_result, res);
        chk("srv_hold_tag", rsp_tag, tag);
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        chk("srv_rsp_cleared", rsp_valid, 1'b0);
    endtask

    task automatic do_op(input logic [1:0] cs, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] tag, input logic [31:0] res);
        push(cs, op, a, b, tag);
        wait_start("op_start");
        chk("op_cond_sel", rt_cond_sel, cs);
        chk("op_opcode", rt_opcode, op);
        chk("op_b", rt_b, b);
        cyc();
        serve(tag, a, res);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_cond_sel = '0; cmd_opcode = '0;
        cmd_a = '0; cmd_b = '0; cmd_tag = '0; rt_busy = 1'b0; rt_done = 1'b0;
        rt_result = '0; rsp_ready = 1'b0;
        cyc(); cyc();
        rst = 1'b0;

        // Reset state
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_rt_start", rt_start, 1'b0);
        chk("rst_rt_a", rt_a, 16'h0);
        chk("rst_rt_opcode", rt_opcode, 4'h0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_result", rsp_result, 32'h0);
        chk("rst_rsp_tag", rsp_tag, 4'h0);
        chk("rst_disp_busy", disp_busy, 1'b0);
        chk("rst_cnt_b2", cnt_b2, 16'h0);

        // Single op, base-2, with exact start/response timing
        cmd_valid = 1'b1; cmd_cond_sel = ROUTE_B2; cmd_opcode = OP_BIN_MUL;
        cmd_a = 16'd3; cmd_b = 16'd5; cmd_tag = 4'd1;
        cyc();
        cmd_valid = 1'b0;
        chk("t1_start_early", rt_start, 1'b0);
        chk("t1_busy", disp_busy, 1'b1);
        cyc();
        chk("t1_start", rt_start, 1'b1);
        chk("t1_cond_sel", rt_cond_sel, 2'd0);
        chk("t1_opcode", rt_opcode, OP_BIN_MUL);
        chk("t1_a", rt_a, 16'd3);
        chk("t1_b", rt_b, 16'd5);
        chk("t1_cnt_b2", cnt_b2, StatsEn ? 16'd1 : 16'd0);
        cyc();
        serve(4'd1, 16'd3, 32'd15);
        chk("t1_idle", disp_busy, 1'b0);
        chk("t1_cnt_b10", cnt_b10, 16'd0);

        // Route by opcode, range boundaries
        do_op(ROUTE_BY_OP, OP_BIN_MUL, 16'd6, 16'd7, 4'd2, 32'd42);
        do_op(ROUTE_BY_OP, OP_DEC_MUL10, 16'd9, 16'd0, 4'd3, 32'd90);
        do_op(ROUTE_BY_OP, OP_DUO_ADD, 16'd11, 16'd1, 4'd4, 32'd12);
        chk("rbo_cnt_b2", cnt_b2, StatsEn ? 16'd2 : 16'd0);
        chk("rbo_cnt_b10", cnt_b10, StatsEn ? 16'd1 : 16'd0);
        chk("rbo_cnt_b12", cnt_b12, StatsEn ? 16'd1 : 16'd0);

        // Operand stability while waiting
        push(ROUTE_B12, OP_DUO_MUL, 16'hA5A5, 16'h5A5A, 4'd7);
        wait_start("st_start");
        for (int i = 0; i < 4; i++) begin
            cmd_cond_sel = 2'(i); cmd_opcode = 4'(i + 9);
            cmd_a = 16'(i * 4099); cmd_b = 16'(~i); cmd_tag = 4'(i);
            cyc();
            chk("st_cond_sel", rt_cond_sel, ROUTE_B12);
            chk("st_opcode", rt_opcode, OP_DUO_MUL);
            chk("st_b", rt_b, 16'h5A5A);
        end
        serve(4'd7, 16'hA5A5, 32'h1234_5678);
        chk("st_cnt_b12", cnt_b12, StatsEn ? 16'd2 : 16'd0);

        // Back-pressure: five commands, consumer stalled
        for (int i = 0; i < 5; i++) begin
            chk("bp_ready", cmd_ready, 1'b1);
            cmd_valid = 1'b1; cmd_cond_sel = ROUTE_B10; cmd_opcode = OP_DEC_ADD;
            cmd_a = 16'(16'h100 + i); cmd_b = 16'd1; cmd_tag = 4'(i);
            cyc();
        end
        cmd_tag = 4'd5; cmd_a = 16'h0BAD;
        chk("bp_full", cmd_ready, 1'b0);
        cyc();
        chk("bp_full_held", cmd_ready, 1'b0);
        cmd_valid = 1'b0;
        serve(4'd0, 16'h100, 32'd1000);
        chk("bp_gap", rt_start, 1'b0);
        cyc();
        chk("bp_next_start", rt_start, 1'b1);
        chk("bp_ready_again", cmd_ready, 1'b1);
        cyc();
        serve(4'd1, 16'h101, 32'd1001);
        for (int i = 2; i < 5; i++) begin
            wait_start("bp_start");
            cyc();
            serve(4'(i), 16'(16'h100 + i), 32'(1000 + i));
        end
        cyc(); cyc(); cyc();
        chk("bp_drained", disp_busy, 1'b0);
        chk("bp_no_extra_start", rt_start, 1'b0);
        chk("bp_overlaps", overlaps, 0);
        chk("bp_cnt_b10", cnt_b10, StatsEn ? 16'd6 : 16'd0);

        // Stray done while idle
        rt_done = 1'b1; rt_result = 32'd99;
        cyc();
        rt_done = 1'b0;
        chk("stray_rsp", rsp_valid, 1'b0);
        chk("stray_busy", disp_busy, 1'b0);
        cyc();
        chk("stray_rsp_late", rsp_valid, 1'b0);

        // Reset mid-WAIT with a second command queued
        push(ROUTE_B2, OP_BIN_ADD, 16'h1234, 16'h0001, 4'd9);
        push(ROUTE_B2, OP_BIN_SUB, 16'h4321, 16'h0002, 4'd10);
        wait_start("rw_start");
        cyc();
        chk("rw_a", rt_a, 16'h1234);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rw_cmd_ready", cmd_ready, 1'b1);
        chk("rw_rt_start", rt_start, 1'b0);
        chk("rw_rt_a", rt_a, 16'h0);
        chk("rw_rt_b", rt_b, 16'h0);
        chk("rw_rsp_valid", rsp_valid, 1'b0);
        chk("rw_busy", disp_busy, 1'b0);
        chk("rw_cnt_b2", cnt_b2, 16'h0);
        chk("rw_cnt_b10", cnt_b10, 16'h0);
        chk("rw_cnt_b12", cnt_b12, 16'h0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("rw_quiet_start", rt_start, 1'b0);
            chk("rw_quiet_rsp", rsp_valid, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
